// File: rtl/uart_rx_word_assembler.sv
// Packs the UART RX byte stream into 32-bit words for the command stage.
// Partial words are dropped on an inter-byte timeout or a frame error.
module uart_rx_word_assembler #(
    parameter bit          MSB_FIRST      = 1'b1,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd100000,
    localparam int         GPU_WORD       = 32
) (
    input  logic                iClock,
    input  logic                iReset,
    input  logic                iUartByteValid,
    input  logic [7:0]          iUartByte,
    input  logic                iUartFrameError,
    output logic                oUartWord32Available,
    output logic [GPU_WORD-1:0] oUartDataRxWord,
    output logic                oBusy,
    output logic [1:0]          oByteCount,
    output logic                oTimeoutError,
    output logic                oFrameError
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_EMIT    = 2'd2;

    logic [1:0]          state_q, state_d;
    logic [1:0]          count_q, count_d;
    logic [23:0]         timer_q, timer_d;
    logic [GPU_WORD-1:0] asm_q,   asm_d;
    logic [GPU_WORD-1:0] word_q,  word_d;
    logic                avail_q, avail_d;
    logic                busy_q,  busy_d;
    logic                terr_q,  terr_d;
    logic                ferr_q,  ferr_d;

    logic                good_byte;
    logic                bad_byte;
    logic [GPU_WORD-1:0] shifted;

    assign good_byte = iUartByteValid && !iUartFrameError;
    assign bad_byte  = iUartByteValid &&  iUartFrameError;
    assign shifted   = MSB_FIRST ? {asm_q[23:0], iUartByte} : {iUartByte, asm_q[31:8]};

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        timer_d = timer_q;
        asm_d   = asm_q;
        word_d  = word_q;
        avail_d = 1'b0;
        terr_d  = 1'b0;
        ferr_d  = 1'b0;

        case (state_q)
            S_COLLECT: begin
                // Byte strobe beats timer expiry; frame error beats both.
                if (bad_byte) begin
                    count_d = 2'd0;
                    timer_d = '0;
                    ferr_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (good_byte) begin
                    asm_d   = shifted;
                    timer_d = '0;
                    if (count_q == 2'd3) begin
                        word_d  = shifted;
                        count_d = 2'd0;
                        avail_d = 1'b1;
                        state_d = S_EMIT;
                    end else begin
                        count_d = count_q + 2'd1;
                    end
                end else if (timer_q >= TIMEOUT_CYCLES) begin
                    count_d = 2'd0;
                    timer_d = '0;
                    terr_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    // Exits before reaching the limit's successor, so no wrap.
                    timer_d = timer_q + 24'd1;
                end
            end
            default: begin
                // IDLE and EMIT both accept a first byte; EMIT always leaves after one cycle.
                count_d = 2'd0;
                timer_d = '0;
                state_d = S_IDLE;
                if (bad_byte) begin
                    ferr_d = 1'b1;
                end else if (good_byte) begin
                    asm_d   = shifted;
                    count_d = 2'd1;
                    state_d = S_COLLECT;
                end
            end
        endcase

        busy_d = (count_d != 2'd0);
    end

    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            state_q <= S_IDLE;
            count_q <= 2'd0;
            timer_q <= '0;
            asm_q   <= '0;
            word_q  <= '0;
            avail_q <= 1'b0;
            busy_q  <= 1'b0;
            terr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            timer_q <= timer_d;
            asm_q   <= asm_d;
            word_q  <= word_d;
            avail_q <= avail_d;
            busy_q  <= busy_d;
            terr_q  <= terr_d;
            ferr_q  <= ferr_d;
        end
    end

    assign oUartWord32Available = avail_q;
    assign oUartDataRxWord      = word_q;
    assign oBusy                = busy_q;
    assign oByteCount           = count_q;
    assign oTimeoutError        = terr_q;
    assign oFrameError          = ferr_q;

endmodule
